imem_fetch_ctrl: RTL and testbench

Controller that owns the single port of a writable, asynchronous-read instruction memory and shares it between two users: a program loader, which streams words in after reset, and the fetch stage, which sequences the word-addressed PC. The block presents registered instruction/PC pairs to decode and handles stall, branch redirect, end-of-program and reload. It sits between the boot/test interface, the instruction memory and the IF/ID pipeline register.

---
 rtl/imem_fetch_ctrl.sv | 157 +++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
//
// Owns the single port of a writable, asynchronous-read instruction memory.
// After reset a program loader streams words into the memory. The fetch stage
// then walks the word-addressed PC and presents registered instruction/PC pairs
// to decode. The block also handles stall, branch redirect, end-of-program
// detection and reload.
//
// Ports:
//   clk, rst        - clock (rising edge) and asynchronous active-high reset
//   load_valid      - loader word valid
//   load_data       - loader word
//   load_last       - final word of the program (qualified by load_valid)
//   load_ready      - loader word accepted this cycle (high in LOAD)
//   restart         - synchronous request to return to LOAD
//   stall           - hold the fetch outputs and the PC
//   branch_taken    - redirect fetch to branch_target this cycle
//   branch_target   - word address of the redirect
//   imem_addr       - memory address: write pointer in LOAD, otherwise PC
//   imem_we         - memory write enable
//   imem_wdata      - memory write data (zero when not writing)
//   imem_rdata      - asynchronous read data at imem_addr
//   instr_out       - registered fetched instruction
//   pc_out          - registered address of instr_out
//   instr_valid     - instr_out/pc_out valid
//   prog_len        - number of words written by the last completed load
//   done            - fetch has run past the last loaded word
// -----------------------------------------------------------------------------
module imem_fetch_ctrl #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned AW    = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_last,
   output logic             load_ready,
   input  logic             restart,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic [AW-1:0]    branch_target,
   output logic [AW-1:0]    imem_addr,
   output logic             imem_we,
   output logic [WIDTH-1:0] imem_wdata,
   input  logic [WIDTH-1:0] imem_rdata,
   output logic [WIDTH-1:0] instr_out,
   output logic [AW-1:0]    pc_out,
   output logic             instr_valid,
   output logic [AW:0]      prog_len,
   output logic             done
);

   typedef enum logic [1:0] {
      StLoad,
      StRun,
      StDone
   } state_e;

   localparam logic [AW-1:0] AddrOne  = AW'(1);
   localparam logic [AW-1:0] AddrLast = {AW{1'b1}};
   localparam logic [AW:0]   LenOne   = (AW+1)'(1);

   state_e        state_q;
   logic [AW-1:0] wptr_q;
   logic [AW-1:0] pc_q;

   // PC at or beyond the loaded image. Zero-extended so a full 2**AW image
   // never matches and the PC simply wraps.
   logic pc_past_end;
   logic target_in_prog;

   assign pc_past_end    = ({1'b0, pc_q} >= prog_len);
   assign target_in_prog = ({1'b0, branch_target} < prog_len);

   // Memory port ownership: loader in LOAD, fetch PC otherwise.
   always_comb begin
      load_ready = (state_q == StLoad);
      imem_we    = load_ready && load_valid;
      imem_wdata = imem_we ? load_data : '0;
      imem_addr  = load_ready ? wptr_q : pc_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StLoad;
         wptr_q      <= '0;
         pc_q        <= '0;
         prog_len    <= '0;
         instr_out   <= '0;
         pc_out      <= '0;
         instr_valid <= 1'b0;
         done        <= 1'b0;
      end else begin
         case (state_q)
            StLoad: begin
               instr_valid <= 1'b0;
               done        <= 1'b0;
               if (restart) begin
                  // A word presented alongside restart is still written, but
                  // the pointer rewinds so the next load overwrites it.
                  wptr_q <= '0;
               end else if (load_valid) begin
                  wptr_q <= wptr_q + AddrOne;
                  if (load_last || (wptr_q == AddrLast)) begin
                     prog_len <= {1'b0, wptr_q} + LenOne;
                     pc_q     <= '0;
                     state_q  <= StRun;
                  end
               end
            end

            StRun: begin
               if (restart) begin
                  state_q     <= StLoad;
                  wptr_q      <= '0;
                  instr_valid <= 1'b0;
               end else if (branch_taken) begin
                  // Redirect wins over stall; the cycle becomes a bubble.
                  pc_q        <= branch_target;
                  instr_valid <= 1'b0;
               end else if (stall) begin
                  // Hold everything.
               end else if (pc_past_end) begin
                  instr_valid <= 1'b0;
                  done        <= 1'b1;
                  state_q     <= StDone;
               end else begin
                  instr_out   <= imem_rdata;
                  pc_out      <= pc_q;
                  instr_valid <= 1'b1;
                  pc_q        <= pc_q + AddrOne;
               end
            end

            StDone: begin
               instr_valid <= 1'b0;
               if (restart) begin
                  state_q <= StLoad;
                  wptr_q  <= '0;
                  done    <= 1'b0;
               end else if (branch_taken && target_in_prog) begin
                  state_q <= StRun;
                  pc_q    <= branch_target;
                  done    <= 1'b0;
               end
            end

            default: begin
               state_q <= StLoad;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned AW    = 9;
   localparam int unsigned DEPTH = 1 << AW;

   logic             clk;
   logic             rst;
   logic             load_valid;
   logic [WIDTH-1:0] load_data;
   logic             load_last;
   logic             load_ready;
   logic             restart;
   logic             stall;
   logic             branch_taken;
   logic [AW-1:0]    branch_target;
   logic [AW-1:0]    imem_addr;
   logic             imem_we;
   logic [WIDTH-1:0] imem_wdata;
   logic [WIDTH-1:0] imem_rdata;
   logic [WIDTH-1:0] instr_out;
   logic [AW-1:0]    pc_out;
   logic             instr_valid;
   logic [AW:0]      prog_len;
   logic             done;

   int checks;
   int errors;

   logic [WIDTH-1:0] mem  [DEPTH];
   logic [WIDTH-1:0] prog [DEPTH];

   imem_fetch_ctrl #(
      .WIDTH(WIDTH),
      .AW   (AW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .load_valid   (load_valid),
      .load_data    (load_data),
      .load_last    (load_last),
      .load_ready   (load_ready),
      .restart      (restart),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .imem_addr    (imem_addr),
      .imem_we      (imem_we),
      .imem_wdata   (imem_wdata),
      .imem_rdata   (imem_rdata),
      .instr_out    (instr_out),
      .pc_out       (pc_out),
      .instr_valid  (instr_valid),
      .prog_len     (prog_len),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory model: synchronous write, asynchronous read.
   always @(posedge clk) begin
      if (imem_we) mem[imem_addr] <= imem_wdata;
   end
   assign imem_rdata = mem[imem_addr];

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      load_valid    = 1'b0;
      load_data     = '0;
      load_last     = 1'b0;
      restart       = 1'b0;
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic fill_prog(input int n, input logic [WIDTH-1:0] seed);
      for (int i = 0; i < n; i++) prog[i] = seed ^ (WIDTH'(i) * 32'h0101_0101);
   endtask

   // Streams prog[0..n-1]; load_last on the final word when use_last is set.
   task automatic load_prog(input int n, input bit use_last);
      for (int i = 0; i < n; i++) begin
         load_valid = 1'b1;
         load_data  = prog[i];
         load_last  = use_last && (i == n - 1);
         #1;
         checks++;
         if (imem_we !== 1'b1 || imem_addr !== AW'(i) || imem_wdata !== prog[i]) begin
            errors++;
            $display("FAIL load_write[%0d]: got we=%b addr=%0d wdata=%h, required we=1 addr=%0d wdata=%h",
                     i, imem_we, imem_addr, imem_wdata, i, prog[i]);
         end
         @(posedge clk);
         #1;
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic check_fetch(input string name, input int pc);
      checks++;
      if (instr_valid !== 1'b1 || pc_out !== AW'(pc) || instr_out !== prog[pc]) begin
         errors++;
         $display("FAIL %s: got valid=%b pc_out=%0d instr=%h, required valid=1 pc_out=%0d instr=%h",
                  name, instr_valid, pc_out, instr_out, pc, prog[pc]);
      end
   endtask

   task automatic check_bubble(input string name, input logic exp_done);
      checks++;
      if (instr_valid !== 1'b0 || done !== exp_done) begin
         errors++;
         $display("FAIL %s: got valid=%b done=%b, required valid=0 done=%b",
                  name, instr_valid, done, exp_done);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      #2;
      checks++;
      if (instr_out !== '0 || pc_out !== '0 || instr_valid !== 1'b0 || done !== 1'b0 ||
          prog_len !== '0 || load_ready !== 1'b1 || imem_we !== 1'b0) begin
         errors++;
         $display("FAIL reset: got instr=%h pc=%0d valid=%b done=%b len=%0d ready=%b we=%b, required 0 0 0 0 0 1 0",
                  instr_out, pc_out, instr_valid, done, prog_len, load_ready, imem_we);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      do_reset();
      prog[0] = 32'h0000_0113;
      prog[1] = 32'h0040_0093;
      prog[2] = 32'h0010_0193;
      prog[3] = 32'h0031_0233;
      load_prog(4, 1'b1);
      checks++;
      if (prog_len !== 10'd4 || load_ready !== 1'b0 || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_enter_run: got len=%0d ready=%b valid=%b, required len=4 ready=0 valid=0",
                  prog_len, load_ready, instr_valid);
      end
      for (int k = 0; k < 4; k++) begin
         step();
         check_fetch("basic_fetch", k);
      end
      step();
      check_bubble("basic_done", 1'b1);
      // Restart from DONE returns to LOAD and clears done.
      restart = 1'b1;
      step();
      restart = 1'b0;
      checks++;
      if (load_ready !== 1'b1 || done !== 1'b0 || imem_addr !== '0) begin
         errors++;
         $display("FAIL restart_from_done: got ready=%b done=%b addr=%0d, required ready=1 done=0 addr=0",
                  load_ready, done, imem_addr);
      end
   endtask

   task automatic test_stall();
      do_reset();
      fill_prog(8, 32'hA500_0000);
      load_prog(8, 1'b1);
      for (int k = 0; k < 3; k++) step();
      check_fetch("stall_pre", 2);
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check_fetch("stall_hold", 2);
      end
      stall = 1'b0;
      step();
      check_fetch("stall_release", 3);
   endtask

   task automatic test_branch();
      do_reset();
      fill_prog(8, 32'h3C00_0000);
      load_prog(8, 1'b1);
      for (int k = 0; k < 5; k++) step();
      check_fetch("branch_pre", 4);
      branch_taken  = 1'b1;
      branch_target = 9'd1;
      stall         = 1'b1;
      step();
      branch_taken = 1'b0;
      stall        = 1'b0;
      check_bubble("branch_bubble", 1'b0);
      step();
      check_fetch("branch_target", 1);
      step();
      check_fetch("branch_next", 2);
   endtask

   task automatic test_branch_oob();
      do_reset();
      fill_prog(8, 32'h0F0F_0000);
      load_prog(8, 1'b1);
      step();
      step();
      check_fetch("oob_pre", 1);
      branch_taken  = 1'b1;
      branch_target = 9'd9;
      step();
      branch_taken = 1'b0;
      check_bubble("oob_bubble", 1'b0);
      step();
      check_bubble("oob_done", 1'b1);
      step();
      check_bubble("oob_done_hold", 1'b1);
      checks++;
      if (imem_addr !== 9'd9) begin
         errors++;
         $display("FAIL oob_pc_hold: got addr=%0d, required addr=9", imem_addr);
      end
      // Out-of-range branch in DONE is ignored.
      branch_taken  = 1'b1;
      branch_target = 9'd8;
      step();
      check_bubble("oob_done_ignore", 1'b1);
      branch_target = 9'd0;
      step();
      branch_taken = 1'b0;
      check_bubble("oob_resume", 1'b0);
      step();
      check_fetch("oob_resume_fetch", 0);
   endtask

   task automatic test_full_load();
      do_reset();
      fill_prog(DEPTH, 32'h5A5A_0000);
      load_prog(DEPTH, 1'b0);
      checks++;
      if (prog_len !== 10'd512 || load_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_len: got len=%0d ready=%b, required len=512 ready=0", prog_len, load_ready);
      end
      load_valid = 1'b1;
      load_data  = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (imem_we !== 1'b0 || imem_wdata !== '0) begin
         errors++;
         $display("FAIL full_ignore_load: got we=%b wdata=%h, required we=0 wdata=0", imem_we, imem_wdata);
      end
      step();
      load_valid = 1'b0;
      check_fetch("full_fetch0", 0);
      step();
      check_fetch("full_fetch1", 1);
   endtask

   task automatic test_async_reset();
      do_reset();
      fill_prog(8, 32'h7700_0000);
      load_prog(8, 1'b1);
      for (int k = 0; k < 6; k++) step();
      check_fetch("areset_pre", 5);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (instr_out !== '0 || pc_out !== '0 || instr_valid !== 1'b0 || prog_len !== '0 ||
          load_ready !== 1'b1) begin
         errors++;
         $display("FAIL areset_outputs: got instr=%h pc=%0d valid=%b len=%0d ready=%b, required 0 0 0 0 1",
                  instr_out, pc_out, instr_valid, prog_len, load_ready);
      end
      step();
      rst = 1'b0;
      prog[0] = 32'hCAFE_0001;
      prog[1] = 32'hCAFE_0002;
      load_prog(2, 1'b1);
      checks++;
      if (prog_len !== 10'd2) begin
         errors++;
         $display("FAIL areset_len: got len=%0d, required len=2", prog_len);
      end
      step();
      check_fetch("areset_fetch0", 0);
      step();
      check_fetch("areset_fetch1", 1);
      step();
      check_bubble("areset_done", 1'b1);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_basic();
      test_stall();
      test_branch();
      test_branch_oob();
      test_full_load();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
